// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared datapath,
// with memory-wait timeout. Define CTRL_PERF_COUNTER_EN to enable the retired-instruction counter.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clock,
   input  logic             resetN,
   input  logic [4:0]       opCode,
   input  logic             zero,
   input  logic             memReady,
   output logic             pcWrite,
   output logic             irWrite,
   output logic             memRead,
   output logic             memWrite,
   output logic             iOrD,
   output logic             regDest,
   output logic             memToReg,
   output logic             regWrite,
   output logic             aluSrcA,
   output logic [1:0]       aluSrcB,
   output logic [1:0]       aluOp,
   output logic [1:0]       pcSource,
   output logic [3:0]       state,
   output logic             halted,
   output logic             illegalOp,
   output logic             memTimeout,
   output logic [CNT_W-1:0] instrCount
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_EXEC_R    = 4'd2;
   localparam logic [3:0] S_WB_R      = 4'd3;
   localparam logic [3:0] S_EXEC_ADDR = 4'd4;
   localparam logic [3:0] S_MEM_RD    = 4'd5;
   localparam logic [3:0] S_WB_MEM    = 4'd6;
   localparam logic [3:0] S_MEM_WR    = 4'd7;
   localparam logic [3:0] S_WB_I      = 4'd8;
   localparam logic [3:0] S_BRANCH    = 4'd9;
   localparam logic [3:0] S_HALT      = 4'd10;

   logic [3:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              is_wait;
   logic              tmo;

   // wait_q counts earlier no-ready cycles, so this cycle is the MEM_TIMEOUT-th one
   assign is_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   assign tmo     = is_wait && !memReady && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
   assign state   = state_q;

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:     state_d = memReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opCode)
               5'd0:             state_d = S_EXEC_R;
               5'd1, 5'd2, 5'd4: state_d = S_EXEC_ADDR;
               5'd3:             state_d = S_BRANCH;
               5'd31:            state_d = S_HALT;
               default:          state_d = S_FETCH;
            endcase
         end
         S_EXEC_R:    state_d = S_WB_R;
         S_WB_R:      state_d = S_FETCH;
         S_EXEC_ADDR: begin
            case (opCode)
               5'd1:    state_d = S_MEM_RD;
               5'd2:    state_d = S_MEM_WR;
               5'd4:    state_d = S_WB_I;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM_RD:    state_d = memReady ? S_WB_MEM : (tmo ? S_FETCH : S_MEM_RD);
         S_WB_MEM:    state_d = S_FETCH;
         S_MEM_WR:    state_d = (memReady || tmo) ? S_FETCH : S_MEM_WR;
         S_WB_I:      state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_FETCH;
      endcase

      // a FETCH timeout re-enters FETCH, so it must clear explicitly
      if (tmo || (state_d != state_q))
         wait_d = '0;
      else if (is_wait && !memReady)
         wait_d = wait_q + WAIT_W'(1);
      else
         wait_d = wait_q;
   end

   always_comb begin
      pcWrite    = 1'b0;
      irWrite    = 1'b0;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      iOrD       = 1'b0;
      regDest    = 1'b0;
      memToReg   = 1'b0;
      regWrite   = 1'b0;
      aluSrcA    = 1'b0;
      aluSrcB    = 2'b00;
      aluOp      = 2'b00;
      pcSource   = 2'b00;
      halted     = 1'b0;
      illegalOp  = 1'b0;
      memTimeout = 1'b0;
      if (resetN) begin
         case (state_q)
            S_FETCH: begin
               memRead    = 1'b1;
               aluSrcB    = 2'b01;
               irWrite    = memReady;
               pcWrite    = memReady;
               memTimeout = tmo;
            end
            S_DECODE: begin
               aluSrcB   = 2'b11;
               illegalOp = !(opCode inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd31});
            end
            S_EXEC_R: begin
               aluSrcA = 1'b1;
               aluOp   = 2'b01;
            end
            S_WB_R: begin
               regDest  = 1'b1;
               regWrite = 1'b1;
            end
            S_EXEC_ADDR: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
            end
            S_MEM_RD: begin
               memRead    = 1'b1;
               iOrD       = 1'b1;
               memTimeout = tmo;
            end
            S_WB_MEM: begin
               memToReg = 1'b1;
               regWrite = 1'b1;
            end
            S_MEM_WR: begin
               memWrite   = 1'b1;
               iOrD       = 1'b1;
               memTimeout = tmo;
            end
            S_WB_I:   regWrite = 1'b1;
            S_BRANCH: begin
               aluSrcA  = 1'b1;
               aluOp    = 2'b10;
               pcSource = 2'b01;
               pcWrite  = zero;
            end
            S_HALT:   halted = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef CTRL_PERF_COUNTER_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   always_comb begin
      case (state_q)
         S_WB_R, S_WB_MEM, S_WB_I, S_BRANCH: retire = 1'b1;
         S_MEM_WR:                           retire = memReady;
         default:                            retire = 1'b0;
      endcase
      cnt_d = cnt_q + CNT_W'(retire);
   end

   always_ff @(posedge clock) begin
      if (!resetN) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign instrCount = cnt_q;
`else
   assign instrCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a randomized
// instruction stream checked against a per-instruction cycle trace model.
module tb_multicycle_control;

   logic        clock = 1'b0;
   logic        resetN;
   logic [4:0]  opCode;
   logic        zero;
   logic        memReady;
   logic        pcWrite, irWrite, memRead, memWrite, iOrD, regDest, memToReg, regWrite, aluSrcA;
   logic [1:0]  aluSrcB, aluOp, pcSource;
   logic [3:0]  state;
   logic        halted, illegalOp, memTimeout;
   logic [15:0] instrCount;

   int          checks;
   int          errors;
   logic [15:0] exp_cnt;

   multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
      .clock(clock), .resetN(resetN), .opCode(opCode), .zero(zero), .memReady(memReady),
      .pcWrite(pcWrite), .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite),
      .iOrD(iOrD), .regDest(regDest), .memToReg(memToReg), .regWrite(regWrite),
      .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
      .state(state), .halted(halted), .illegalOp(illegalOp), .memTimeout(memTimeout),
      .instrCount(instrCount)
   );

   always #5 clock = ~clock;

   logic [17:0] ctl_obs;
   assign ctl_obs = {pcWrite, irWrite, memRead, memWrite, iOrD, regDest, memToReg, regWrite,
                     aluSrcA, aluSrcB, aluOp, pcSource, halted, illegalOp, memTimeout};

   typedef struct {
      int          st;
      bit          rdy;
      bit          z;
      logic [4:0]  op;
      bit          ret;
      logic [17:0] ctl;
   } cyc_t;
   cyc_t q[$];

   function automatic logic [15:0] exp_ic();
`ifdef CTRL_PERF_COUNTER_EN
      return exp_cnt;
`else
      return 16'd0;
`endif
   endfunction

   // Output table per named step (0=FETCH .. 10=HALT)
   function automatic logic [17:0] exp_ctl(int st, bit rdy, bit z, bit ill, bit tmo);
      logic pw, iw, mr, mw, iod, rd, m2r, rw, sa, h;
      logic [1:0] sb, op, ps;
      {pw, iw, mr, mw, iod, rd, m2r, rw, sa, h} = '0;
      sb = 2'b00; op = 2'b00; ps = 2'b00;
      case (st)
         0:  begin mr = 1; sb = 2'b01; iw = rdy; pw = rdy; end
         1:  sb = 2'b11;
         2:  begin sa = 1; op = 2'b01; end
         3:  begin rd = 1; rw = 1; end
         4:  begin sa = 1; sb = 2'b10; end
         5:  begin mr = 1; iod = 1; end
         6:  begin m2r = 1; rw = 1; end
         7:  begin mw = 1; iod = 1; end
         8:  rw = 1;
         9:  begin sa = 1; op = 2'b10; ps = 2'b01; pw = z; end
         10: h = 1;
         default: ;
      endcase
      return {pw, iw, mr, mw, iod, rd, m2r, rw, sa, sb, op, ps, h, ill, tmo};
   endfunction

   function automatic void push(int st, bit rdy, logic [4:0] op, bit tmo, bit ret);
      cyc_t c;
      bit   ill;
      ill   = (st == 1) && !(op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd31});
      c.st  = st;
      c.rdy = rdy;
      c.z   = 1'($urandom_range(0, 1));
      c.op  = op;
      c.ret = ret;
      c.ctl = exp_ctl(st, rdy, c.z, ill, tmo);
      q.push_back(c);
   endfunction

   // One instruction's expected cycle trace; waits of 15+ no-ready cycles are abandoned
   function automatic void gen_instr();
      int         k, df, dm, wst;
      logic [4:0] op;
      k  = $urandom_range(0, 5);
      op = (k == 5) ? 5'($urandom_range(5, 30)) : 5'(k);
      df = $urandom_range(0, 17);
      if (df >= 15) begin
         for (int i = 0; i < 15; i++) push(0, 0, op, i == 14, 0);
         df = $urandom_range(0, 3);
      end
      for (int i = 0; i < df; i++) push(0, 0, op, 0, 0);
      push(0, 1, op, 0, 0);
      push(1, 1'($urandom_range(0, 1)), op, 0, 0);
      case (op)
         5'd0: begin push(2, 1'($urandom_range(0, 1)), op, 0, 0); push(3, 1'($urandom_range(0, 1)), op, 0, 1); end
         5'd3: push(9, 1'($urandom_range(0, 1)), op, 0, 1);
         5'd4: begin push(4, 1'($urandom_range(0, 1)), op, 0, 0); push(8, 1'($urandom_range(0, 1)), op, 0, 1); end
         5'd1, 5'd2: begin
            push(4, 1'($urandom_range(0, 1)), op, 0, 0);
            wst = (op == 5'd1) ? 5 : 7;
            dm  = $urandom_range(0, 17);
            if (dm >= 15) begin
               for (int i = 0; i < 15; i++) push(wst, 0, op, i == 14, 0);
            end else begin
               for (int i = 0; i < dm; i++) push(wst, 0, op, 0, 0);
               push(wst, 1, op, 0, op == 5'd2);
               if (op == 5'd1) push(6, 1'($urandom_range(0, 1)), op, 0, 1);
            end
         end
         default: ;
      endcase
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      resetN = 0; memReady = 1; zero = 1; opCode = 0;
      tick(); tick();
      #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
      checks++; if (ctl_obs !== 18'd0) begin errors++; $display("FAIL reset_ctl_forced got %h want 0", ctl_obs); end
      checks++; if (instrCount !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", instrCount); end
      resetN = 1; exp_cnt = 0;
      #1;
      checks++; if (ctl_obs !== exp_ctl(0, 1, 1, 0, 0)) begin errors++; $display("FAIL reset_release_ctl got %h want %h", ctl_obs, exp_ctl(0, 1, 1, 0, 0)); end
   endtask

   task automatic test_rtype();
      int es[5] = '{0, 1, 2, 3, 0};
      opCode = 0;
      for (int i = 0; i < 5; i++) begin
         memReady = 1; #1;
         checks++; if (state !== 4'(es[i])) begin errors++; $display("FAIL rtype_state cyc %0d got %0d want %0d", i, state, es[i]); end
         checks++; if ({regWrite, regDest} !== {2{i == 3}}) begin errors++; $display("FAIL rtype_wb cyc %0d got %b want %b", i, {regWrite, regDest}, {2{i == 3}}); end
         if (i == 3) exp_cnt++;
         if (i < 4) tick();
      end
      checks++; if (instrCount !== exp_ic()) begin errors++; $display("FAIL rtype_count got %0d want %0d", instrCount, exp_ic()); end
   endtask

   task automatic test_lw_wait();
      int es[9] = '{0, 1, 4, 5, 5, 5, 5, 6, 0};
      bit rd[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
      opCode = 1;
      for (int i = 0; i < 9; i++) begin
         memReady = rd[i]; #1;
         checks++; if (state !== 4'(es[i])) begin errors++; $display("FAIL lw_state cyc %0d got %0d want %0d", i, state, es[i]); end
         if (es[i] == 5) begin
            checks++; if ({memRead, iOrD, memWrite} !== 3'b110) begin errors++; $display("FAIL lw_memrd cyc %0d got %b want 110", i, {memRead, iOrD, memWrite}); end
         end
         if (es[i] == 6) begin
            checks++; if ({memToReg, regWrite} !== 2'b11) begin errors++; $display("FAIL lw_wbmem got %b want 11", {memToReg, regWrite}); end
         end
         if (i == 7) exp_cnt++;
         if (i < 8) tick();
      end
   endtask

   task automatic test_branch();
      int es[4] = '{0, 1, 9, 0};
      opCode = 3; memReady = 1;
      for (int z = 0; z < 2; z++) begin
         zero = 1'(z);
         for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (state !== 4'(es[i])) begin errors++; $display("FAIL beq_state z=%0d cyc %0d got %0d want %0d", z, i, state, es[i]); end
            if (i == 2) begin
               checks++; if ({pcWrite, pcSource} !== {1'(z), 2'b01}) begin errors++; $display("FAIL beq_pc z=%0d got %b want %b", z, {pcWrite, pcSource}, {1'(z), 2'b01}); end
               exp_cnt++;
            end
            if (i < 3) tick();
         end
      end
   endtask

   task automatic test_illegal();
      int es[3] = '{0, 1, 0};
      opCode = 7; memReady = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (state !== 4'(es[i])) begin errors++; $display("FAIL illegal_state cyc %0d got %0d want %0d", i, state, es[i]); end
         checks++; if (illegalOp !== (i == 1)) begin errors++; $display("FAIL illegal_pulse cyc %0d got %b want %b", i, illegalOp, i == 1); end
         if (i < 2) tick();
      end
      checks++; if (instrCount !== exp_ic()) begin errors++; $display("FAIL illegal_count got %0d want %0d", instrCount, exp_ic()); end
   endtask

   task automatic test_fetch_timeout();
      opCode = 0; memReady = 0;
      for (int i = 1; i <= 15; i++) begin
         #1;
         checks++; if ({state, irWrite, memTimeout} !== {4'd0, 1'b0, 1'(i == 15)}) begin
            errors++; $display("FAIL fetch_tmo cyc %0d got st=%0d ir=%b tmo=%b want st=0 ir=0 tmo=%b", i, state, irWrite, memTimeout, i == 15);
         end
         tick();
      end
      for (int i = 1; i <= 15; i++) begin
         memReady = (i == 15); #1;
         checks++; if ({state, irWrite, memTimeout} !== {4'd0, 1'(i == 15), 1'b0}) begin
            errors++; $display("FAIL fetch_ready15 cyc %0d got st=%0d ir=%b tmo=%b want st=0 ir=%b tmo=0", i, state, irWrite, memTimeout, i == 15);
         end
         tick();
      end
      #1;
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL fetch_ready15_decode got %0d want 1", state); end
      tick(); tick();
      exp_cnt++;
      tick();
      checks++; if (instrCount !== exp_ic()) begin errors++; $display("FAIL fetch_tmo_count got %0d want %0d", instrCount, exp_ic()); end
   endtask

   task automatic test_random();
      q.delete();
      for (int n = 0; n < 80; n++) gen_instr();
      for (int i = 0; i < q.size(); i++) begin
         opCode = q[i].op; memReady = q[i].rdy; zero = q[i].z;
         #1;
         checks++; if (state !== 4'(q[i].st)) begin errors++; $display("FAIL rand_state idx %0d got %0d want %0d", i, state, q[i].st); end
         checks++; if (ctl_obs !== q[i].ctl) begin errors++; $display("FAIL rand_ctl idx %0d st %0d got %h want %h", i, q[i].st, ctl_obs, q[i].ctl); end
         checks++; if (instrCount !== exp_ic()) begin errors++; $display("FAIL rand_count idx %0d got %0d want %0d", i, instrCount, exp_ic()); end
         if (q[i].ret) exp_cnt++;
         tick();
      end
      #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL rand_end_state got %0d want 0", state); end
   endtask

   task automatic test_halt();
      opCode = 31; memReady = 1;
      tick(); tick();
      for (int i = 0; i < 6; i++) begin
         opCode = 5'($urandom_range(0, 31)); memReady = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
         #1;
         checks++; if (state !== 4'd10) begin errors++; $display("FAIL halt_state cyc %0d got %0d want 10", i, state); end
         checks++; if (ctl_obs !== exp_ctl(10, 0, 0, 0, 0)) begin errors++; $display("FAIL halt_ctl cyc %0d got %h want %h", i, ctl_obs, exp_ctl(10, 0, 0, 0, 0)); end
         tick();
      end
      resetN = 0; #1;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_forced got %b want 0", halted); end
      tick();
      resetN = 1; exp_cnt = 0; #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL halt_exit_state got %0d want 0", state); end
   endtask

   task automatic test_reset_mid_write();
      opCode = 2; memReady = 1;
      tick(); tick(); tick();
      memReady = 0; #1;
      checks++; if ({state, memWrite} !== {4'd7, 1'b1}) begin errors++; $display("FAIL sw_wait got st=%0d mw=%b want st=7 mw=1", state, memWrite); end
      resetN = 0; #1;
      checks++; if (memWrite !== 1'b0) begin errors++; $display("FAIL sw_reset_drop got %b want 0", memWrite); end
      tick();
      exp_cnt = 0;
      checks++; if ({state, instrCount} !== {4'd0, 16'd0}) begin errors++; $display("FAIL sw_reset_after got st=%0d cnt=%0d want 0 0", state, instrCount); end
      resetN = 1;
   endtask

   initial begin
      checks = 0; errors = 0; exp_cnt = 0;
      resetN = 0; opCode = 0; zero = 0; memReady = 0;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_branch();
      test_illegal();
      test_fetch_timeout();
      test_random();
      test_halt();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
